// File: rtl/cnt_param.sv
// Parameterised up/down counter with prescaler, wrap/saturate boundary modes,
// a combinational terminal-count strobe for cascading and a sticky boundary flag.
module cnt_param #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             stepNow;
    logic             atBound;

    // With PRESCALE=1 PRE_MAX is 0, so pre never leaves 0 and every enabled cycle steps.
    always_comb begin
        stepNow = en && !clr && !load && (pre_q == PRE_MAX);
        atBound = up ? (cnt_q == CNT_MAX) : (cnt_q == '0);
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            cnt_d = '0;
            pre_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            cnt_d = ({1'b0, din} < MOD_EXT) ? din : CNT_MAX;
            pre_d = '0;
        end else if (en) begin
            pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
            if (stepNow) begin
                if (atBound) begin
                    ovf_d = 1'b1;
                    if (!sat) begin
                        cnt_d = up ? '0 : CNT_MAX;
                    end
                end else begin
                    cnt_d = up ? cnt_q + 1'b1 : cnt_q - 1'b1;
                end
            end
        end
    end

    // Gated by rst_n so a downstream stage never sees a step while this one is held in reset.
    assign tc  = rst_n && stepNow && atBound;
    assign cnt = cnt_q;
    assign ovf = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_cnt_param.sv
// Directed bench for cnt_param: modulo-10 counter, prescaled counter,
// full-range modulo-16 counter and a two-stage decimal cascade share the stimulus.
module tb_cnt_param;

    logic       clk = 1'b0;
    logic       rst_n, en, clr, load, up, sat;
    logic [3:0] din;

    logic [3:0] aCnt, pCnt, wCnt, c0Cnt, c1Cnt;
    logic       aTc, pTc, wTc, c0Tc, c1Tc;
    logic       aOvf, pOvf, wOvf, c0Ovf, c1Ovf;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    cnt_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dutA (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .din(din),
        .up(up), .sat(sat), .cnt(aCnt), .tc(aTc), .ovf(aOvf));

    cnt_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dutP (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .din(din),
        .up(up), .sat(sat), .cnt(pCnt), .tc(pTc), .ovf(pOvf));

    cnt_param #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dutW (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .din(din),
        .up(up), .sat(sat), .cnt(wCnt), .tc(wTc), .ovf(wOvf));

    cnt_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dutC0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .din(din),
        .up(up), .sat(sat), .cnt(c0Cnt), .tc(c0Tc), .ovf(c0Ovf));

    cnt_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dutC1 (
        .clk(clk), .rst_n(rst_n), .en(c0Tc), .clr(clr), .load(load), .din(din),
        .up(up), .sat(sat), .cnt(c1Cnt), .tc(c1Tc), .ovf(c1Ovf));

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and settle before any tc check.
    task automatic applyStimulus(input logic e, input logic c, input logic l,
                                 input logic [3:0] d, input logic u, input logic s);
        en   = e;
        clr  = c;
        load = l;
        din  = d;
        up   = u;
        sat  = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int tcExp[4]   = '{0, 0, 1, 1};
        int cntExp[4]  = '{1, 0, 0, 0};
        int ovfExp[4]  = '{0, 0, 1, 1};
        int enPat[8]   = '{1, 1, 0, 1, 1, 1, 0, 1};
        int preExp[8]  = '{0, 0, 0, 1, 1, 1, 1, 2};
        int relExp[3]  = '{0, 0, 1};

        rst_n = 1'b0;
        applyStimulus(1, 0, 1, 4'd7, 1, 0);
        tick();
        checkOutput("reset cnt", aCnt, 0);
        checkOutput("reset ovf", aOvf, 0);
        applyStimulus(1, 0, 0, 4'd0, 0, 0);
        checkOutput("reset tc gated", aTc, 0);
        tick();

        // Modulo-10 up count with wrap
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1, 0, 0, 4'd0, 1, 0);
            checkOutput("mod10 tc", aTc, ((i - 1) % 10 == 9) ? 1 : 0);
            tick();
            checkOutput("mod10 cnt", aCnt, i % 10);
            checkOutput("mod10 ovf", aOvf, (i >= 10) ? 1 : 0);
        end

        // Saturating down count from a loaded value
        applyStimulus(0, 1, 0, 4'd0, 0, 1);
        tick();
        checkOutput("clr ovf", aOvf, 0);
        applyStimulus(0, 0, 1, 4'd2, 0, 1);
        tick();
        checkOutput("load 2", aCnt, 2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 4'd0, 0, 1);
            checkOutput("satdn tc", aTc, tcExp[i]);
            tick();
            checkOutput("satdn cnt", aCnt, cntExp[i]);
            checkOutput("satdn ovf", aOvf, ovfExp[i]);
        end

        // Out-of-range load clamps; clr beats load and drops ovf
        applyStimulus(0, 0, 1, 4'd15, 1, 0);
        tick();
        checkOutput("load clamp", aCnt, 9);
        applyStimulus(1, 0, 1, 4'd15, 1, 0);
        checkOutput("load tc gated", aTc, 0);
        tick();
        checkOutput("load hold", aCnt, 9);
        checkOutput("load keeps ovf", aOvf, 1);
        applyStimulus(1, 1, 1, 4'd15, 1, 0);
        checkOutput("clr tc gated", aTc, 0);
        tick();
        checkOutput("clr+load cnt", aCnt, 0);
        checkOutput("clr+load ovf", aOvf, 0);

        // Full-range modulus behaves as natural 4-bit arithmetic
        applyStimulus(1, 0, 0, 4'd0, 0, 0);
        checkOutput("mod16 tc", wTc, 1);
        tick();
        checkOutput("mod16 down wrap", wCnt, 15);
        checkOutput("mod16 ovf", wOvf, 1);
        applyStimulus(1, 0, 0, 4'd0, 1, 1);
        tick();
        checkOutput("mod16 sat hold", wCnt, 15);
        applyStimulus(1, 0, 0, 4'd0, 1, 0);
        tick();
        checkOutput("mod16 up wrap", wCnt, 0);

        // Prescale 3 with gaps in enable
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 4'd0, 1, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(enPat[i] != 0, 0, 0, 4'd0, 1, 0);
            tick();
            checkOutput("prescale cnt", pCnt, preExp[i]);
        end

        // Reset mid-prescale discards progress and overrides load
        applyStimulus(0, 0, 1, 4'd5, 1, 0);
        tick();
        checkOutput("pre load 5", pCnt, 5);
        applyStimulus(1, 0, 0, 4'd0, 1, 0);
        tick();
        checkOutput("pre partial", pCnt, 5);
        rst_n = 1'b0;
        applyStimulus(1, 0, 1, 4'd5, 1, 0);
        checkOutput("rst tc", pTc, 0);
        tick();
        checkOutput("rst cnt", pCnt, 0);
        checkOutput("rst ovf", pOvf, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 4'd0, 1, 0);
            tick();
            checkOutput("post-rst cnt", pCnt, relExp[i]);
        end

        // Two decimal stages cascaded through tc
        applyStimulus(0, 1, 0, 4'd0, 1, 0);
        tick();
        for (int i = 1; i <= 100; i++) begin
            applyStimulus(1, 0, 0, 4'd0, 1, 0);
            checkOutput("cascade tc", c1Tc, ((i - 1) % 100 == 99) ? 1 : 0);
            tick();
            checkOutput("cascade pair", int'(c1Cnt) * 10 + int'(c0Cnt), i % 100);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
